// File: rtl/vedic_mul8_seq.sv
// Purpose: unsigned 8x8 multiply built from four passes through one shared 4x4 multiplier.
// Latency: 5 cycles from accept to out_valid (1 cycle when a zero operand is bypassed).
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module vedic_mul8_seq #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        LL,
        LH,
        HL,
        HH,
        DONE
    } state_t;

    // Latched operand pair; stays constant for the whole multiply.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } opnd_t;

    state_t      state_q, state_d;
    opnd_t       opnd_q, opnd_d;
    logic [15:0] acc_q, acc_d;
    logic        in_zero;

    assign in_zero = (in_a == 8'd0) || (in_b == 8'd0);

    // State, operand and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
        end
    end

    // Pass sequencing: pick the nibble pair for this pass and fold its product into acc.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        mul_a   = 4'd0;
        mul_b   = 4'd0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opnd_d.a = in_a;
                    opnd_d.b = in_b;
                    acc_d    = 16'd0;
                    state_d  = (ZERO_BYPASS && in_zero) ? DONE : LL;
                end
            end
            LL: begin
                mul_a   = opnd_q.a[3:0];
                mul_b   = opnd_q.b[3:0];
                acc_d   = acc_q + {8'h00, mul_p};
                state_d = LH;
            end
            LH: begin
                mul_a   = opnd_q.a[3:0];
                mul_b   = opnd_q.b[7:4];
                acc_d   = acc_q + {4'h0, mul_p, 4'h0};
                state_d = HL;
            end
            HL: begin
                mul_a   = opnd_q.a[7:4];
                mul_b   = opnd_q.b[3:0];
                acc_d   = acc_q + {4'h0, mul_p, 4'h0};
                state_d = HH;
            end
            HH: begin
                mul_a   = opnd_q.a[7:4];
                mul_b   = opnd_q.b[7:4];
                acc_d   = acc_q + {mul_p, 8'h00};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_p     = acc_q;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
`timescale 1ns/1ps
module tb_vedic_mul8_seq;

    localparam bit ZB = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, busy;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic [15:0] out_p;

    // Second instance with the bypass disabled.
    logic        z_in_valid = 1'b0;
    logic [7:0]  z_in_a = 8'd0;
    logic [7:0]  z_in_b = 8'd0;
    logic        z_in_ready, z_out_valid, z_busy;
    logic [3:0]  z_mul_a, z_mul_b;
    logic [7:0]  z_mul_p;
    logic [15:0] z_out_p;

    int npass = 0;
    int ntotal = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    // Golden 4x4 multipliers on the shared-multiplier ports.
    assign mul_p   = {4'h0, mul_a} * {4'h0, mul_b};
    assign z_mul_p = {4'h0, z_mul_a} * {4'h0, z_mul_b};

    vedic_mul8_seq #(.ZERO_BYPASS(ZB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    vedic_mul8_seq #(.ZERO_BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_a(z_in_a), .in_b(z_in_b), .mul_a(z_mul_a), .mul_b(z_mul_b), .mul_p(z_mul_p),
        .out_valid(z_out_valid), .out_ready(1'b1), .out_p(z_out_p), .busy(z_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a job is described only by its operands and the
    // number of cycles elapsed since it was accepted.
    logic        m_act = 1'b0;
    int          m_t = 0;
    logic [7:0]  m_a = 8'd0, m_b = 8'd0;
    logic        m_byp = 1'b0;
    logic [15:0] m_last = 16'd0;

    function automatic bit m_done(input bit byp, input int t);
        return byp ? (t >= 1) : (t >= 5);
    endfunction

    // Pass k (1..4): nibble product weighted by its position.
    function automatic logic [15:0] term(input logic [7:0] a, input logic [7:0] b, input int k);
        int al, ah, bl, bh;
        al = a % 16; ah = a / 16; bl = b % 16; bh = b / 16;
        case (k)
            1: return 16'(al * bl);
            2: return 16'(al * bh * 16);
            3: return 16'(ah * bl * 16);
            default: return 16'(ah * bh * 256);
        endcase
    endfunction

    function automatic logic [15:0] partial(input logic [7:0] a, input logic [7:0] b, input int k);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 1; i <= k; i++) s = s + term(a, b, i);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_last <= 16'd0;
        end else if (!m_act) begin
            if (in_valid) begin
                m_act <= 1'b1;
                m_t   <= 1;
                m_a   <= in_a;
                m_b   <= in_b;
                m_byp <= ZB && (in_a == 8'd0 || in_b == 8'd0);
            end
        end else if (m_done(m_byp, m_t) && out_ready) begin
            m_act  <= 1'b0;
            m_last <= 16'(m_a) * 16'(m_b);
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Compare every DUT output against the model each cycle.
    always @(negedge clk) begin
        logic [15:0] ep;
        logic [3:0]  ea, eb;
        logic        dn;
        if (chk_en) begin
            dn = m_act && m_done(m_byp, m_t);
            ea = 4'd0;
            eb = 4'd0;
            if (!m_act) ep = m_last;
            else if (dn) ep = 16'(m_a) * 16'(m_b);
            else begin
                ep = partial(m_a, m_b, m_t - 1);
                ea = (m_t <= 2) ? m_a[3:0] : m_a[7:4];
                eb = (m_t % 2 == 1) ? m_b[3:0] : m_b[7:4];
            end
            chk("in_ready", 32'(in_ready), 32'(!m_act));
            chk("busy", 32'(busy), 32'(m_act));
            chk("out_valid", 32'(out_valid), 32'(dn));
            chk("out_p", 32'(out_p), 32'(ep));
            chk("mul_a", 32'(mul_a), 32'(ea));
            chk("mul_b", 32'(mul_b), 32'(eb));
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    // One directed multiply; result and latency are checked against literals.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                          input logic [15:0] exp, input bit stall);
        int lat;
        logic [15:0] cap;
        wait_idle();
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = !stall;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        cap = out_p;
        chk("result", 32'(cap), 32'(exp));
        if (stall) begin
            for (int i = 0; i < 3; i++) begin
                if (i == 0) begin
                    in_valid = 1'b1;
                    in_a     = 8'h11;
                    in_b     = 8'h22;
                end
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_p", 32'(out_p), 32'(cap));
                chk("stall_rdy", 32'(in_ready), 32'd0);
                chk("stall_busy", 32'(busy), 32'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("rdy_after_hs", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk("held_accepted", 32'(busy), 32'd1);
            wait_idle();
            chk("held_result", 32'(out_p), 32'h0242);
        end else begin
            @(negedge clk);
            chk("rdy_after_hs", 32'(in_ready), 32'd1);
        end
    endtask

    function automatic logic [7:0] rnd8();
        if ($urandom_range(0, 7) == 0) return 8'd0;
        return 8'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit acc_pend;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_out_p", 32'(out_p), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Bypass disabled: zero operand still takes the full pass sequence.
        z_in_valid = 1'b1;
        z_in_a     = 8'h00;
        z_in_b     = 8'hFF;
        @(negedge clk);
        z_in_valid = 1'b0;
        lat = 1;
        while (!z_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("nobyp_latency", 32'(lat), 32'd5);
        chk("nobyp_result", 32'(z_out_p), 32'd0);

        run_op(8'h03, 8'h05, 5, 16'h000F, 1'b0);
        run_op(8'hAC, 8'h5B, 5, 16'h3D24, 1'b0);
        run_op(8'hFF, 8'hFF, 5, 16'hFE01, 1'b0);
        run_op(8'h00, 8'hFF, 1, 16'h0000, 1'b0);
        run_op(8'h3A, 8'h5C, 5, 16'h14D8, 1'b1);

        // Reset during HL of 0x77*0x99.
        wait_idle();
        in_valid = 1'b1;
        in_a     = 8'h77;
        in_b     = 8'h99;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hl_mul_a", 32'(mul_a), 32'h7);
        chk("hl_mul_b", 32'(mul_b), 32'h9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_p", 32'(out_p), 32'd0);
        chk("rstmid_rdy", 32'(in_ready), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        run_op(8'h12, 8'h34, 5, 16'h03A8, 1'b0);

        // Random traffic with random sink backpressure; the model checks every cycle.
        in_valid = 1'b0;
        acc_pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!in_valid || acc_pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = rnd8();
                in_b     = rnd8();
            end
            acc_pend  = in_valid && in_ready;
            out_ready = ($urandom_range(0, 9) < 7);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
